// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared pipeline tag type and VRAM geometry for the VRAM arbiter
package vram_arb_pkg;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} arb_tag_t;
    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;
    localparam int STAT_W = 16;
endpackage

// File: rtl/vram_arb_stats.sv
// vram_arb_stats: saturating count of CPU stall cycles, clear has priority
module vram_arb_stats
    import vram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [STAT_W-1:0] o_cnt
);
    logic [STAT_W-1:0] r_cnt;
    // count stall cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset || i_clr) r_cnt <= '0;
        else if (i_inc && r_cnt != {STAT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: video-priority VRAM arbiter, grant/RAM/capture pipeline; stall counter under VRAM_ARB_STATS_EN
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       stat_stall_cnt,
    input  logic              stat_clr
);
    arb_tag_t          r_tag0, r_tag1;
    logic              r_busy;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_vid_valid;
    logic [DATA_W-1:0] r_vid_data;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              w_cpu_idle;
    logic              w_cpu_grant;

    // the ack cycle still belongs to the old request, so a held cpu_req cannot be re-granted in it
    assign w_cpu_idle  = !r_busy && !r_cpu_ack;
    assign w_cpu_grant = cpu_req && w_cpu_idle && !vid_req;
    assign cpu_wait    = cpu_req && w_cpu_idle && vid_req;

    // stage 0: grant one requester per cycle and register the RAM command
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag0      <= TAG_NONE;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else if (vid_req) begin
            r_tag0     <= TAG_VID;
            r_ram_addr <= vid_addr;
            r_ram_we   <= 1'b0;
        end else if (w_cpu_grant) begin
            r_tag0      <= TAG_CPU;
            r_ram_addr  <= cpu_addr;
            r_ram_we    <= cpu_we;
            r_ram_wdata <= cpu_wdata;
        end else begin
            r_tag0   <= TAG_NONE;
            r_ram_we <= 1'b0;
        end
    end

    // stages 1-2: follow the RAM access and capture its read data for the owner
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag1      <= TAG_NONE;
            r_busy      <= 1'b0;
            r_vid_valid <= 1'b0;
            r_vid_data  <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_tag1      <= r_tag0;
            r_vid_valid <= r_tag1 == TAG_VID;
            r_cpu_ack   <= r_tag1 == TAG_CPU;
            if (r_tag1 == TAG_VID) r_vid_data <= ram_rdata;
            if (r_tag1 == TAG_CPU) r_cpu_rdata <= ram_rdata;
            r_busy      <= w_cpu_grant ? 1'b1 : (r_tag1 == TAG_CPU) ? 1'b0 : r_busy;
        end
    end

    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
    assign vid_valid = r_vid_valid;
    assign vid_data  = r_vid_data;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;

`ifdef VRAM_ARB_STATS_EN
    vram_arb_stats u_stats (
        .clk   (clk),
        .reset (reset),
        .i_inc (cpu_wait),
        .i_clr (stat_clr),
        .o_cnt (stat_stall_cnt)
    );
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = stat_clr;
    assign stat_stall_cnt    = '0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench with a transaction-level arbiter model and a VRAM behavioural model
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vid_req = 1'b0;
    logic [12:0] vid_addr = '0;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [15:0] stat_stall_cnt;
    logic        stat_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stat_stall_cnt(stat_stall_cnt), .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;

    // VRAM macro: synchronous, read-before-write
    logic [7:0] sram [8192];
    always @(posedge clk) begin
        ram_rdata <= sram[ram_addr];
        if (ram_we) sram[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: a grant becomes a result two edges later; the CPU may be
    // re-granted only once its grant, two pipeline edges and its ack cycle have passed.
    logic [7:0]  mmem [8192];
    logic [1:0]  pk [2];
    logic [7:0]  pd [2];
    int          m_left = 0;
    logic        m_init = 1'b0;
    logic        e_vv, e_ack, e_ack_rd, e_we;
    logic [7:0]  e_vd, e_rd, e_wd;
    logic [12:0] e_addr;
    logic [15:0] e_stat;

    initial forever begin
        logic elig;
        @(posedge clk);
        if (!reset) begin
            pk[0] = 0; pk[1] = 0; m_left = 0; m_init = 1'b1;
            e_vv = 0; e_ack = 0; e_ack_rd = 0; e_we = 0;
            e_vd = 0; e_rd = 0; e_wd = 0; e_addr = 0; e_stat = 0;
        end else begin
            elig = m_left == 0;
            if (m_left > 0) m_left--;
            e_vv = pk[1] == 1;
            e_ack = pk[1] >= 2;
            e_ack_rd = pk[1] == 2;
            if (pk[1] == 1) e_vd = pd[1];
            if (pk[1] != 0) e_rd = pd[1];
            pk[1] = pk[0]; pd[1] = pd[0];
            pk[0] = 0; e_we = 0;
`ifdef VRAM_ARB_STATS_EN
            if (stat_clr) e_stat = 0;
            else if (cpu_req && vid_req && elig && e_stat != 16'hFFFF) e_stat = e_stat + 1;
`endif
            if (vid_req) begin
                pk[0] = 1; pd[0] = mmem[vid_addr]; e_addr = vid_addr;
            end else if (cpu_req && elig) begin
                pk[0] = cpu_we ? 2'd3 : 2'd2; pd[0] = mmem[cpu_addr];
                e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata;
                if (cpu_we) mmem[cpu_addr] = cpu_wdata;
                m_left = 3;
            end
        end
    end

    // compare DUT against the model mid-cycle
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("vid_valid", vid_valid, e_vv);
            chk("vid_data", vid_data, e_vd);
            chk("cpu_ack", cpu_ack, e_ack);
            if (e_ack_rd) chk("cpu_rdata", cpu_rdata, e_rd);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_we", ram_we, e_we);
            if (e_we) chk("ram_wdata", ram_wdata, e_wd);
            chk("cpu_wait", cpu_wait, cpu_req && vid_req && m_left == 0);
            chk("stat_stall_cnt", stat_stall_cnt, e_stat);
        end
    end

    task automatic wait_ack(output int n, output int nwe);
        n = 0; nwe = 0;
        do begin
            tick();
            n++;
            if (ram_we) nwe++;
        end while (!cpu_ack && n < 20);
        chk("ack_arrived", cpu_ack, 1);
    endtask

    initial begin
        int n, nwe, nw, na, second;
        for (int i = 0; i < 8192; i++) begin
            sram[i] = 8'(i) ^ 8'(i >> 5);
            mmem[i] = sram[i];
        end
        tick(); tick();
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        reset = 1'b1;

        // write 0x5A to 0x0100, then read it back
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0100; cpu_wdata = 8'h5A;
        wait_ack(n, nwe);
        chk("t1_wr_lat", n, 3);
        chk("t1_we_cycles", nwe, 1);
        cpu_req = 0; tick();
        cpu_we = 0; cpu_req = 1;
        wait_ack(n, nwe);
        chk("t1_rd_lat", n, 3);
        chk("t1_rdata", cpu_rdata, 8'h5A);
        chk("t1_rd_we_cycles", nwe, 0);
        cpu_req = 0; tick();

        // simultaneous video and CPU requests
        vid_req = 1; vid_addr = 13'h0000; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1800;
        #1 chk("t2_wait", cpu_wait, 1);
        tick(); vid_req = 0;
        #1 chk("t2_wait_off", cpu_wait, 0);
        tick(); chk("t2_cpu_grant_addr", ram_addr, 13'h1800);
        tick(); chk("t2_vid_valid", vid_valid, 1); chk("t2_no_ack_yet", cpu_ack, 0);
        tick(); chk("t2_cpu_ack", cpu_ack, 1); chk("t2_vid_done", vid_valid, 0);
        chk("t2_rdata", cpu_rdata, 8'hC0);
        cpu_req = 0; tick();

        // ten cycles of video starve a pending CPU read
        stat_clr = 1; tick(); stat_clr = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0200; vid_req = 1;
        nw = 0; na = 0;
        for (int i = 0; i < 10; i++) begin
            vid_addr = 13'h0040 + 13'(i);
            #1;
            nw += int'(cpu_wait);
            tick();
            na += int'(cpu_ack);
        end
        vid_req = 0;
        chk("t3_wait_cycles", nw, 10);
        chk("t3_no_ack", na, 0);
`ifdef VRAM_ARB_STATS_EN
        chk("t3_stat", stat_stall_cnt, 10);
`else
        chk("t3_stat_off", stat_stall_cnt, 0);
`endif
        wait_ack(n, nwe);
        chk("t3_lat", n, 3);
        chk("t3_rdata", cpu_rdata, 8'h10);
        cpu_req = 0; tick();

        // cpu_req held across the ack: one access per request
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0300; cpu_wdata = 8'h3C;
        na = 0; second = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (cpu_ack) begin
                na++;
                if (na == 2) second = i;
            end
        end
        cpu_req = 0;
        chk("t4_acks", na, 2);
        chk("t4_second_ack", second, 7);
        tick();

        // back-to-back video reads of freshly written and untouched locations
        vid_req = 1; vid_addr = 13'h0100; tick();
        vid_addr = 13'h0300; tick();
        vid_addr = 13'h1800; tick();
        vid_addr = 13'h1FE0; tick();
        vid_req = 0; tick(); tick();
        chk("vs_last_valid", vid_valid, 1);
        chk("vs_last_data", vid_data, 8'h1F);
        tick();

        // reset one cycle after a CPU read grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0100; tick();
        reset = 0; cpu_req = 0; tick();
        chk("t5_cpu_ack", cpu_ack, 0);
        chk("t5_vid_valid", vid_valid, 0);
        chk("t5_vid_data", vid_data, 0);
        chk("t5_cpu_rdata", cpu_rdata, 0);
        chk("t5_ram_addr", ram_addr, 0);
        chk("t5_ram_we", ram_we, 0);
        chk("t5_stat", stat_stall_cnt, 0);
        reset = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0400; cpu_wdata = 8'h77; tick();
        chk("t5_we_set", ram_we, 1);
        reset = 0; cpu_req = 0; tick();
        chk("t5_we_cleared", ram_we, 0);
        reset = 1;
        na = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            na += int'(cpu_ack);
        end
        chk("t5_no_ack", na, 0);

        // stall counter saturation and clear priority
        vid_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0010;
`ifdef VRAM_ARB_STATS_EN
        repeat (65534) tick();
        chk("t6_preload", stat_stall_cnt, 16'hFFFE);
        repeat (3) tick();
        chk("t6_saturate", stat_stall_cnt, 16'hFFFF);
        stat_clr = 1; tick(); stat_clr = 0;
        chk("t6_clear", stat_stall_cnt, 0);
`else
        stat_clr = 1; tick(); stat_clr = 0; tick();
        chk("t6_stat_off", stat_stall_cnt, 0);
`endif
        vid_req = 0;
        wait_ack(n, nwe);
        chk("t6_lat", n, 3);
        cpu_req = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
